// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// also used by the baud generator and the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_t;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; the reset value is
// chosen so that an idle line does not look like activity coming out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery feeding a one-entry
// valid/ready holding register, with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int TW = clog2_min1(OVERSAMPLE);
  localparam int BW = clog2_min1(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state_q,     state_d;
  logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
  logic [BW-1:0]        bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 busy_q,      busy_d;
  logic                 consume;
  logic                 deliver;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign consume = valid_q && i_ready;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (consume) begin
      valid_d = 1'b0;
    end

    if (i_sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              state_d    = ST_IDLE;
              tick_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              deliver = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_BREAK: begin
          // Stay put through a break or stuck-low line so it cannot re-trigger.
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end

    // A slot freed by same-cycle consumption can take the new byte.
    if (deliver) begin
      if (!valid_q || consume) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level model of the receiver's
// holding register and error flags.
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int CPT = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sample_tick = 1'b0;
  logic          i_rx = 1'b1;
  logic          i_ready = 1'b0;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  int fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0, drop_viol = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, valid_prev = 1'b0, hs_edge = 1'b0;

  bit            model_valid = 1'b0;
  logic [DB-1:0] model_data  = '0;
  int            exp_fe = 0, exp_ov = 0;

  int div = 0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sample_tick (i_sample_tick),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #2;
    i_sample_tick = (div == CPT - 1);
    div = (div + 1) % CPT;
  end

  always @(posedge i_clk) hs_edge <= o_valid && i_ready;

  // Flag pulse counting and the rule that o_valid only falls on a handshake.
  always @(negedge i_clk) begin
    if (o_frame_err) fe_cycles++;
    if (o_frame_err && !fe_prev) fe_pulses++;
    if (o_overrun) ov_cycles++;
    if (o_overrun && !ov_prev) ov_pulses++;
    if (!i_rst && valid_prev && !o_valid && !hs_edge) drop_viol++;
    fe_prev    = o_frame_err;
    ov_prev    = o_overrun;
    valid_prev = o_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge i_clk); while (!i_sample_tick);
    end
  endtask

  task automatic drive(input logic v);
    #1 i_rx = v;
  endtask

  task automatic send_start_data(input logic [DB-1:0] b);
    drive(1'b0);
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      drive(b[i]);
      wait_ticks(OS);
    end
  endtask

  // Frame-level reference: what the holding register and flags should become.
  task automatic model_frame(input logic [DB-1:0] b, input bit stop_good, input bit consumed_same);
    if (!stop_good) exp_fe++;
    else if (model_valid && !consumed_same) exp_ov++;
    else begin
      model_valid = 1'b1;
      model_data  = b;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input bit stop_good);
    send_start_data(b);
    drive(stop_good);
    wait_ticks(OS);
    if (!stop_good) begin
      drive(1'b1);
      wait_ticks(2);
    end
    model_frame(b, stop_good, 1'b0);
  endtask

  task automatic consume();
    @(negedge i_clk) i_ready = 1'b1;
    @(negedge i_clk) i_ready = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    @(negedge i_clk);
    check({tag, "_valid"},  32'(o_valid), 32'(model_valid));
    check({tag, "_data"},   32'(o_data),  32'(model_data));
    check({tag, "_ferr"},   fe_pulses,    exp_fe);
    check({tag, "_ferr_w"}, fe_cycles,    exp_fe);
    check({tag, "_ovr"},    ov_pulses,    exp_ov);
    check({tag, "_ovr_w"},  ov_cycles,    exp_ov);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DB-1:0] rb;
    bit            rgood;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_data",  32'(o_data),      32'h0);
    check("rst_valid", 32'(o_valid),     32'h0);
    check("rst_ferr",  32'(o_frame_err), 32'h0);
    check("rst_ovr",   32'(o_overrun),   32'h0);
    check("rst_busy",  32'(o_busy),      32'h0);
    i_rst = 1'b0;
    wait_ticks(4);

    send_frame(8'h41, 1'b1);
    check_all("t41");
    consume();
    check_all("t41_cons");

    // Short low glitch must abort at mid start bit.
    wait_ticks(1);
    drive(1'b0);
    wait_ticks(3);
    @(negedge i_clk);
    check("glitch_busy", 32'(o_busy), 32'h1);
    wait_ticks(2);
    drive(1'b1);
    wait_ticks(12);
    @(negedge i_clk);
    check("glitch_idle", 32'(o_busy), 32'h0);
    check_all("glitch");

    wait_ticks(1);
    send_start_data(8'h55);
    drive(1'b0);
    wait_ticks(OS + 8);
    @(negedge i_clk);
    check("break_busy", 32'(o_busy), 32'h1);
    check("break_ferr", fe_pulses, 1);
    wait_ticks(2 * OS - 8);
    drive(1'b1);
    model_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(2);
    @(negedge i_clk);
    check("break_exit", 32'(o_busy), 32'h0);
    check_all("t55");
    wait_ticks(1);
    send_frame(8'h7A, 1'b1);
    check_all("t7a");
    consume();

    wait_ticks(1);
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    check_all("ovr");
    consume();
    check_all("ovr_cons");

    // Consume 0x62 on the exact cycle 0x63 is delivered.
    wait_ticks(1);
    send_frame(8'h62, 1'b1);
    check_all("t62");
    wait_ticks(1);
    send_start_data(8'h63);
    drive(1'b1);
    wait_ticks(8);
    do @(negedge i_clk); while (!i_sample_tick);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    wait_ticks(7);
    model_frame(8'h63, 1'b1, 1'b1);
    check_all("same_cycle");

    // Reset during data bit 4 of 0x33 while 0x63 is still held.
    wait_ticks(1);
    drive(1'b0);
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      drive(1'(8'h33 >> i));
      wait_ticks(OS);
    end
    drive(1'b1);
    wait_ticks(8);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mrst_data",  32'(o_data),  32'h0);
    check("mrst_valid", 32'(o_valid), 32'h0);
    check("mrst_busy",  32'(o_busy),  32'h0);
    model_valid = 1'b0;
    model_data  = '0;
    i_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    wait_ticks(20);
    check_all("mrst_idle");
    send_frame(8'h34, 1'b1);
    check_all("t34");
    consume();

    for (int f = 0; f < 10; f++) begin
      rb    = DB'($urandom);
      rgood = ($urandom_range(0, 4) != 0);
      send_frame(rb, rgood);
      check_all($sformatf("rnd%0d", f));
      if ($urandom_range(0, 1) == 1) consume();
      wait_ticks($urandom_range(0, 6));
    end

    check("no_valid_drop", drop_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
